// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: state encoding, frame constants, parity helper
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic PARITY_ODD = 1'b1;

    // State encoding shared by uart_tx and uart_rx.
    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_START_ENC  = 3'd1;
    localparam logic [2:0] ST_DATA_ENC   = 3'd2;
    localparam logic [2:0] ST_PARITY_ENC = 3'd3;
    localparam logic [2:0] ST_STOP_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_START  = ST_START_ENC,
        ST_DATA   = ST_DATA_ENC,
        ST_PARITY = ST_PARITY_ENC,
        ST_STOP   = ST_STOP_ENC
    } uart_state_e;

    // Returns 1 when data plus parity bit violate the configured parity sense.
    function automatic logic parity_error(input logic [DATA_BITS-1:0] data, input logic p);
        parity_error = PARITY_ODD ? ~(^{data, p}) : (^{data, p});
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver-side signal bundle
// Signals: rx (serial line), rx_data, done, valid, parity_err, frame_err, busy.
// With UART_RX_OVERRUN_EN: rx_ack (consumer acknowledge), overrun.
// master: the receiver (uart_rx). slave: the line driver / byte consumer.
interface uart_rx_if import uart_pkg::*; ();
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 done;
    logic                 valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_OVERRUN_EN
    logic                 rx_ack;
    logic                 overrun;

    modport master (input rx, rx_ack,
                    output rx_data, done, valid, parity_err, frame_err, busy, overrun);
    modport slave  (output rx, rx_ack,
                    input rx_data, done, valid, parity_err, frame_err, busy, overrun);
`else
    modport master (input rx,
                    output rx_data, done, valid, parity_err, frame_err, busy);
    modport slave  (output rx,
                    input rx_data, done, valid, parity_err, frame_err, busy);
`endif
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with clear and half-period tick select
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : hold counter at 0 (no tick while cleared)
//   half_i     : tick at mid-bit (CYCLES_PER_BIT/2-1) instead of end of bit
//   tick_o     : one-cycle tick; counter restarts from 0 after every tick
module uart_baud_gen #(
    parameter int CYCLES_PER_BIT = 3125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick;

    assign tick   = ~clear_i && (count_q == (half_i ? HALF_LAST : FULL_LAST));
    assign tick_o = tick;

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear_i || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 1 start, 8 data LSB first, odd parity, 1 stop
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_rx_if.master (rx in; rx_data, done, valid, parity_err,
//                frame_err, busy out; rx_ack in / overrun out with UART_RX_OVERRUN_EN)
// Optional feature macro: UART_RX_OVERRUN_EN (sticky pending/overrun tracking).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ       = 30_000_000,
    parameter int CYCLES_PER_BIT = 3125
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master bus
);

    // A bit shorter than 4 clocks cannot be mid-sampled, and a bit longer than
    // one second of clock is a misconfiguration; fall back to the minimum.
    localparam int CPB = (CYCLES_PER_BIT < 4 || CYCLES_PER_BIT > CLK_FREQ) ? 4 : CYCLES_PER_BIT;
    localparam int IDX_W = $clog2(DATA_BITS);

    // Two-flop synchroniser plus a third flop for falling-edge detection.
    // Preset high so reset release never looks like a start edge.
    logic rx_meta_q, rx_s_q, rx_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    logic start_det;
    assign start_det = rx_d_q & ~rx_s_q;

    uart_state_e          state_q, state_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 baud_clear, baud_half, tick;
    logic                 perr_now, ferr_now;

    uart_baud_gen #(
        .CYCLES_PER_BIT(CPB)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(baud_clear),
        .half_i (baud_half),
        .tick_o (tick)
    );

    assign perr_now = parity_error(shift_q, par_q);
    assign ferr_now = ~rx_s_q;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        baud_clear = 1'b0;
        baud_half  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_clear = 1'b1;
                if (start_det) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // First tick lands mid start bit; the line must still be low.
                baud_half = 1'b1;
                if (tick) begin
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_d   = rx_s_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at stop mid-bit so a back-to-back start edge is not missed.
                if (tick) begin
                    done_d  = 1'b1;
                    perr_d  = perr_now;
                    ferr_d  = ferr_now;
                    valid_d = ~(perr_now | ferr_now);
                    if (!(perr_now | ferr_now)) begin
                        data_d = shift_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            data_q    <= data_d;
        end
    end

    assign bus.rx_data    = data_q;
    assign bus.done       = done_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != ST_IDLE);

`ifdef UART_RX_OVERRUN_EN
    // pending marks an unconsumed byte; a new done on top of it is an overrun.
    // An ack in the same cycle as done consumes the old byte, so no overrun.
    logic pending_q, pending_d;
    logic overrun_q, overrun_d;

    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (bus.rx_ack) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (done_q) begin
            pending_d = 1'b1;
            if (pending_q && !bus.rx_ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun = overrun_q;
`endif

endmodule
